// File: rtl/power_rail_sequencer.sv
// power_rail_sequencer
// Brings NUM_RAILS regulator enables up in index order and down in reverse
// order. Every power-good input is debounced, each step has a timeout, and
// the first failing rail is latched. All decisions run on a divided tick
// enable; there are no derived clocks.
// Optional feature macro: POWER_SEQ_AUTO_RETRY_EN. When it is defined, the
// sequencer may restart up to 3 times after a fault, then locks out in OFF
// until clear_fault.
module power_rail_sequencer #(
  parameter int NUM_RAILS      = 4,
  parameter int TICK_DIV       = 500,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int TIMEOUT_TICKS  = 255,
  parameter int RESTART_TICKS  = 250
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear_fault,
  input  logic [NUM_RAILS-1:0] rail_good,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 all_good,
  output logic                 fault,
  output logic [3:0]           fault_rail,
  output logic [1:0]           state,
  output logic [3:0]           rail_idx
);

  localparam int              TW          = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [3:0]      DEB_MAX     = 4'(DEBOUNCE_TICKS);
  localparam logic [7:0]      TIMEOUT_VAL = 8'(TIMEOUT_TICKS);
  localparam logic [7:0]      RESTART_VAL = 8'(RESTART_TICKS);
  localparam logic [3:0]      LAST_IDX    = 4'(NUM_RAILS - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_nxt;
  logic [3:0]             idx_nxt;
  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic [3:0]             db_cnt [NUM_RAILS];
  logic [NUM_RAILS-1:0]   ok;
  logic                   ok_cur;
  logic [NUM_RAILS-1:0]   fail_mask;
  logic [7:0]             step_timer;
  logic                   timeout;
  logic                   fault_set;
  logic [3:0]             fault_idx;
  logic                   clear_req;
  logic                   start_ok;

  // Lowest set bit of a failing-rail mask; this is the rail reported on a fault.
  function automatic logic [3:0] lowest_set(input logic [NUM_RAILS-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign tick    = (tick_cnt == TICK_LAST);
  assign timeout = (step_timer == TIMEOUT_VAL);
  assign state   = state_q;

  // Free-running tick divider; tick is a one-cycle pulse at the top count.
  always_ff @(posedge sysclk) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Per-rail debounce: a low sample restarts the count, good samples saturate.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int j = 0; j < NUM_RAILS; j++) db_cnt[j] <= '0;
    end else if (tick) begin
      for (int j = 0; j < NUM_RAILS; j++) begin
        if (!rail_good[j])            db_cnt[j] <= '0;
        else if (db_cnt[j] != DEB_MAX) db_cnt[j] <= db_cnt[j] + 4'd1;
      end
    end
  end

  // A rail counts as ok only once its debounce count is saturated.
  always_comb begin
    ok = '0;
    for (int j = 0; j < NUM_RAILS; j++) ok[j] = (db_cnt[j] == DEB_MAX);
  end

  // Step timer restarts whenever the state or step index moves.
  always_ff @(posedge sysclk) begin
    if (reset)                                              step_timer <= '0;
    else if ((state_nxt != state_q) || (idx_nxt != rail_idx)) step_timer <= '0;
    else if (tick && (step_timer != 8'hFF))                 step_timer <= step_timer + 8'd1;
  end

`ifdef POWER_SEQ_AUTO_RETRY_EN
  logic [1:0] retry_cnt;

  assign start_ok = !fault || (retry_cnt != 2'd3);

  // Counts restarts taken while a fault is latched; a clean ON run forgives them.
  always_ff @(posedge sysclk) begin
    if (reset)                                          retry_cnt <= '0;
    else if (clear_req)                                 retry_cnt <= '0;
    else if ((state_nxt == ST_ON) && (state_q != ST_ON)) retry_cnt <= '0;
    else if ((state_q == ST_OFF) && (state_nxt == ST_UP) && fault)
                                                        retry_cnt <= retry_cnt + 2'd1;
  end
`else
  assign start_ok = !fault;
`endif

  // State register: sequencer phase and current step index.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= ST_OFF;
      rail_idx <= '0;
    end else begin
      state_q  <= state_nxt;
      rail_idx <= idx_nxt;
    end
  end

  // Next-state logic; only tick cycles may move the sequencer.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = rail_idx;
    fault_set = 1'b0;
    fault_idx = '0;
    clear_req = 1'b0;
    ok_cur    = 1'b0;
    fail_mask = '0;
    for (int j = 0; j < NUM_RAILS; j++) begin
      if (int'(rail_idx) == j) ok_cur = ok[j];
    end
    if (tick) begin
      case (state_q)
        ST_OFF: begin
          if (clear_fault) begin
            clear_req = 1'b1;
          end else if (enable && (step_timer >= RESTART_VAL) && start_ok) begin
            state_nxt = ST_UP;
            idx_nxt   = '0;
          end
        end
        ST_UP: begin
          // Rails already up must stay ok; the current rail fails only by timeout.
          for (int j = 0; j < NUM_RAILS; j++) begin
            fail_mask[j] = ((j < int'(rail_idx)) && !ok[j]) ||
                           (timeout && (j == int'(rail_idx)));
          end
          if (|fail_mask) begin
            fault_set = 1'b1;
            fault_idx = lowest_set(fail_mask);
          end
          if (!enable || (|fail_mask)) begin
            state_nxt = ST_DOWN;
          end else if (ok_cur) begin
            if (rail_idx == LAST_IDX) state_nxt = ST_ON;
            else                      idx_nxt   = rail_idx + 4'd1;
          end
        end
        ST_ON: begin
          fail_mask = ~ok;
          if (|fail_mask) begin
            fault_set = 1'b1;
            fault_idx = lowest_set(fail_mask);
          end
          if ((|fail_mask) || !enable) begin
            state_nxt = ST_DOWN;
            idx_nxt   = LAST_IDX;
          end
        end
        ST_DOWN: begin
          // Wait for the rail just switched off to drop, or give up on timeout.
          if (!ok_cur || timeout) begin
            if (rail_idx == 4'd0) state_nxt = ST_OFF;
            else                  idx_nxt   = rail_idx - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // First-fault latch; a clear in OFF is the only way out.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_rail <= '0;
    end else if (clear_req) begin
      fault      <= 1'b0;
      fault_rail <= '0;
    end else if (fault_set && !fault) begin
      fault      <= 1'b1;
      fault_rail <= fault_idx;
    end
  end

  // Regulator enables decoded from phase and index; reset kills them at once.
  always_comb begin
    rail_en = '0;
    for (int j = 0; j < NUM_RAILS; j++) begin
      case (state_q)
        ST_UP:   rail_en[j] = (j <= int'(rail_idx));
        ST_ON:   rail_en[j] = 1'b1;
        ST_DOWN: rail_en[j] = (j < int'(rail_idx));
        default: rail_en[j] = 1'b0;
      endcase
    end
    if (reset) rail_en = '0;
    all_good = (state_q == ST_ON);
  end

endmodule
